// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register file constants, index/data types and index qualification helper
package riscv_pkg;
  localparam int RISC_V_DATA_WIDTH = 32;
  localparam int REGISTER_FILE_NUM = 32;
  localparam int REGISTER_FILE_ADDRESS_WIDTH = $clog2(REGISTER_FILE_NUM);
  typedef logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [RISC_V_DATA_WIDTH-1:0] reg_data_t;
  // An index addresses real storage only if in range and not the hardwired x0
  function automatic logic idx_ok(input int idx, input int n, input int zero_x0);
    return idx < n && !(zero_x0 != 0 && idx == 0);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, claim beats clear, registered per-port lookup
module rf_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = REGISTER_FILE_NUM,
  parameter int ADDR_W = REGISTER_FILE_ADDRESS_WIDTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_X0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_num,
  input  logic [NUM_WR-1:0]        w_en,
  input  logic [NUM_WR*ADDR_W-1:0] reg_num_w,
  input  logic [NUM_RD*ADDR_W-1:0] reg_num_r,
  output logic [NUM_RD-1:0]        r_busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_RD-1:0] r_busy_q, r_busy_d;
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++)
      if (w_en[k] && idx_ok(int'(reg_num_w[k*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_X0))
        busy_d[reg_num_w[k*ADDR_W +: ADDR_W]] = 1'b0;
    if (claim_en && idx_ok(int'(claim_num), NUM_REGS, ZERO_X0))
      busy_d[claim_num] = 1'b1;
    r_busy_d = '0;
    for (int p = 0; p < NUM_RD; p++)
      if (idx_ok(int'(reg_num_r[p*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_X0))
        r_busy_d[p] = busy_d[reg_num_r[p*ADDR_W +: ADDR_W]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      r_busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      r_busy_q <= r_busy_d;
    end
  end
  assign r_busy = r_busy_q;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with registered write-first reads and busy scoreboard
module register_file_mp
  import riscv_pkg::*;
#(
  parameter int DATA_W = RISC_V_DATA_WIDTH,
  parameter int NUM_REGS = REGISTER_FILE_NUM,
  parameter int ADDR_W = REGISTER_FILE_ADDRESS_WIDTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_X0 = 1,
  parameter int DEBUG_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] reg_num_r,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  output logic [NUM_RD-1:0]        r_busy,
  input  logic [NUM_WR-1:0]        w_en,
  input  logic [NUM_WR*ADDR_W-1:0] reg_num_w,
  input  logic [NUM_WR*DATA_W-1:0] w_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_num,
  output logic [15:0]              debug
);
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] r_data_q, r_data_d;
  // Later write ports overwrite earlier ones; reads see the post-write array
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NUM_WR; k++)
      if (w_en[k] && idx_ok(int'(reg_num_w[k*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_X0))
        rf_d[reg_num_w[k*ADDR_W +: ADDR_W]] = w_data[k*DATA_W +: DATA_W];
    r_data_d = '0;
    for (int p = 0; p < NUM_RD; p++)
      if (idx_ok(int'(reg_num_r[p*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_X0))
        r_data_d[p*DATA_W +: DATA_W] = rf_d[reg_num_r[p*ADDR_W +: ADDR_W]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '{default: '0};
      r_data_q <= '0;
    end else begin
      rf_q <= rf_d;
      r_data_q <= r_data_d;
    end
  end
  assign r_data = r_data_q;
  assign debug = rf_q[DEBUG_REG][15:0];
  rf_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR),
    .ZERO_X0(ZERO_X0)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .claim_en(claim_en),
    .claim_num(claim_num),
    .w_en(w_en),
    .reg_num_w(reg_num_w),
    .reg_num_r(reg_num_r),
    .r_busy(r_busy)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed vectors, expected responses queued and checked by a separate monitor
module tb_register_file_mp;
  typedef struct {
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [15:0] dbg;
  } exp_t;
  logic clk = 0;
  logic rst;
  logic [9:0] reg_num_r;
  logic [63:0] r_data;
  logic [1:0] r_busy;
  logic [1:0] w_en;
  logic [9:0] reg_num_w;
  logic [63:0] w_data;
  logic claim_en;
  logic [4:0] claim_num;
  logic [15:0] debug;
  int checks = 0;
  int errors = 0;
  logic issue = 0;
  logic issued_q = 0;
  exp_t q[$];
  exp_t e;
  register_file_mp #(.NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk),
    .rst(rst),
    .reg_num_r(reg_num_r),
    .r_data(r_data),
    .r_busy(r_busy),
    .w_en(w_en),
    .reg_num_w(reg_num_w),
    .w_data(w_data),
    .claim_en(claim_en),
    .claim_num(claim_num),
    .debug(debug)
  );
  always #5 clk = ~clk;
  always @(posedge clk) issued_q <= issue;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (issued_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: output with no expectation queued");
      end else begin
        e = q.pop_front();
        chk("r_data0", r_data[31:0], e.d0);
        chk("r_busy0", {31'd0, r_busy[0]}, {31'd0, e.b0});
        chk("r_data1", r_data[63:32], e.d1);
        chk("r_busy1", {31'd0, r_busy[1]}, {31'd0, e.b1});
        chk("debug", {16'd0, debug}, {16'd0, e.dbg});
      end
    end
  end
  task automatic step(input logic rs, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic ce, input logic [4:0] cn,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic ck,
                      input logic [31:0] d0, input logic b0,
                      input logic [31:0] d1, input logic b1, input logic [15:0] dg);
    exp_t x;
    @(negedge clk);
    rst = rs;
    w_en = we;
    reg_num_w = {wa1, wa0};
    w_data = {wd1, wd0};
    claim_en = ce;
    claim_num = cn;
    reg_num_r = {ra1, ra0};
    x.d0 = d0; x.b0 = b0; x.d1 = d1; x.b1 = b1; x.dbg = dg;
    if (ck) q.push_back(x);
    issue = ck;
  endtask
  initial begin
    rst = 1; w_en = 0; reg_num_w = 0; w_data = 0; claim_en = 0; claim_num = 0; reg_num_r = 0;
    //   rst we  wa0 wd0           wa1 wd1    ce cn  ra0 ra1 ck d0            b0 d1            b1 dbg
    step(1, 2'b00, 0, 0,            0, 0,     0, 0,  5, 9,  1, 0,            0, 0,            0, 0);
    step(0, 2'b11, 5, 5,            6, 6,     0, 0,  5, 6,  1, 5,            0, 6,            0, 0);
    step(0, 2'b11, 7, 7,            8, 8,     1, 5,  5, 8,  1, 5,            1, 8,            0, 0);
    step(0, 2'b01, 9, 9,            0, 0,     0, 0,  9, 7,  1, 9,            0, 7,            0, 0);
    step(1, 2'b01, 9, 32'h99,       0, 0,     1, 6,  5, 9,  1, 0,            0, 0,            0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  5, 9,  1, 0,            0, 0,            0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  6, 8,  1, 0,            0, 0,            0, 0);
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0,  5, 0,  1, 32'hDEADBEEF, 0, 0,            0, 0);
    step(0, 2'b01, 0, 32'h1234,     0, 0,     1, 0,  0, 5,  1, 0,            0, 32'hDEADBEEF, 0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 0,  1, 0,            0, 0,            0, 0);
    step(0, 2'b11, 7, 32'hA,        7, 32'hB, 0, 0,  7, 5,  1, 32'hB,        0, 32'hDEADBEEF, 0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  5, 7,  1, 32'hDEADBEEF, 0, 32'hB,        0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     1, 3,  3, 7,  1, 0,            1, 32'hB,        0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  3, 3,  1, 0,            1, 0,            1, 0);
    step(0, 2'b01, 3, 3,            0, 0,     0, 0,  3, 3,  1, 3,            0, 3,            0, 0);
    step(0, 2'b01, 3, 32'h33,       0, 0,     1, 3,  3, 3,  1, 32'h33,       1, 32'h33,       1, 0);
    step(0, 2'b10, 0, 0,            3, 32'h44, 0, 0, 3, 3,  1, 32'h44,       0, 32'h44,       0, 0);
    step(0, 2'b01, 31, 32'h0001ABCD, 0, 0,    0, 0,  31, 3, 1, 32'h0001ABCD, 0, 32'h44,       0, 16'hABCD);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  31, 0, 1, 32'h0001ABCD, 0, 0,            0, 16'hABCD);
    step(1, 2'b01, 31, 32'hFFFF0000, 0, 0,    0, 0,  31, 3, 1, 0,            0, 0,            0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  31, 3, 1, 0,            0, 0,            0, 0);
    step(0, 2'b00, 0, 0,            0, 0,     0, 0,  0, 0,  0, 0,            0, 0,            0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
